// File: rtl/conv_bcd_bin_if.sv
// Request/response bundle for the BCD-to-binary converter.
// The requester drives inicio/dato_bcd; the converter returns status and result.
interface conv_bcd_bin_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  inicio;
  logic [4*DIGITS-1:0]   dato_bcd;
  logic                  ocupado;
  logic                  listo;
  logic [BIN_W-1:0]      dato_bin;
  logic                  error_bcd;

  modport master (
    output inicio, dato_bcd,
    input  ocupado, listo, dato_bin, error_bcd
  );

  modport slave (
    input  inicio, dato_bcd,
    output ocupado, listo, dato_bin, error_bcd
  );
endinterface

// File: rtl/conv_bcd_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Operands with any nibble above 9 are flagged and return all-ones instead of a value.
module conv_bcd_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic               clk,
  input  logic               reset,
  conv_bcd_bin_if.slave      bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state_reg, state_next;
  logic [BCD_W-1:0]       bcd_reg;
  logic [BIN_W-1:0]       bin_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   err_reg;
  logic                   listo_reg;
  logic [BIN_W-1:0]       dato_bin_reg;
  logic                   error_bcd_reg;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       sh_bcd;
  logic [BIN_W-1:0]       sh_bin;
  logic [BCD_W-1:0]       adj_bcd;
  logic [DIGITS-1:0]      nib_bad;
  logic                   load;

  assign shifted = {bcd_reg, bin_reg} >> 1;
  assign sh_bcd  = shifted[BCD_W+BIN_W-1:BIN_W];
  assign sh_bin  = shifted[BIN_W-1:0];

  // Per-digit correction after the shift: a digit that picked up a carried-in 8 is worth 5.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign adj_bcd[gi*4 +: 4] = (sh_bcd[gi*4 +: 4] >= 4'd8) ? (sh_bcd[gi*4 +: 4] - 4'd3)
                                                           : sh_bcd[gi*4 +: 4];
    assign nib_bad[gi] = (bcd_reg[gi*4 +: 4] > 4'd9);
  end

  assign load = bus.inicio && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.inicio) state_next = S_CHECK;
      S_CHECK: state_next = (|nib_bad) ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt_reg == CNT_W'(BIN_W - 1)) state_next = S_DONE;
      S_DONE:  state_next = bus.inicio ? S_CHECK : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      bcd_reg       <= '0;
      bin_reg       <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      listo_reg     <= 1'b0;
      dato_bin_reg  <= '0;
      error_bcd_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      listo_reg <= 1'b0;
      // DONE publishes the previous result on the same edge a new operand may be loaded.
      if (state_reg == S_DONE) begin
        listo_reg     <= 1'b1;
        dato_bin_reg  <= err_reg ? {BIN_W{1'b1}} : bin_reg;
        error_bcd_reg <= err_reg;
      end
      if (load) begin
        bcd_reg <= bus.dato_bcd;
        bin_reg <= '0;
        cnt_reg <= '0;
        err_reg <= 1'b0;
      end
      if (state_reg == S_CHECK) begin
        err_reg <= |nib_bad;
      end
      if (state_reg == S_SHIFT) begin
        bcd_reg <= adj_bcd;
        bin_reg <= sh_bin;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.ocupado   = (state_reg == S_CHECK) || (state_reg == S_SHIFT);
  assign bus.listo     = listo_reg;
  assign bus.dato_bin  = dato_bin_reg;
  assign bus.error_bcd = error_bcd_reg;
endmodule

// File: tb/tb_conv_bcd_bin.sv
// Bench for conv_bcd_bin: directed vectors plus an arithmetic reference model
// checked against the outputs on every cycle after the first reset.
module tb_conv_bcd_bin;
  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic clk;
  logic reset;

  conv_bcd_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  conv_bcd_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               at;
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               n_done = 0;
  int               e_cnt = 0;
  int               ready_at = 0;
  bit               started = 0;
  logic [BIN_W-1:0] held_bin = '0;
  logic             held_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, expv, expv, $time);
    end
  endtask

  // Reference: value is the weighted sum of decimal digits; any digit over 9 is an error.
  function automatic void ref_conv(input logic [4*DIGITS-1:0] b,
                                   output logic [BIN_W-1:0] bin, output logic err);
    int v;
    int w;
    logic [3:0] nib;
    v = 0;
    w = 1;
    err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = b[i*4 +: 4];
      if (nib > 4'd9) err = 1'b1;
      v += int'(nib) * w;
      w *= 10;
    end
    bin = err ? {BIN_W{1'b1}} : BIN_W'(v);
  endfunction

  // Model: tracks acceptance and when each result must appear.
  always @(posedge clk) begin
    logic [BIN_W-1:0] b;
    logic             er;
    int               lat;
    e_cnt++;
    if (!reset) begin
      exp_q.delete();
      ready_at = e_cnt + 1;
      held_bin = '0;
      held_err = 1'b0;
      started  = 1'b1;
    end else if (bus.inicio && e_cnt >= ready_at) begin
      ref_conv(bus.dato_bcd, b, er);
      lat = er ? 2 : BIN_W + 2;
      exp_q.push_back('{at: e_cnt + lat, bin: b, err: er});
      ready_at = e_cnt + lat;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic exp_listo;
    if (started) begin
      exp_listo = (exp_q.size() > 0) && (exp_q[0].at <= e_cnt);
      chk("listo", 32'(bus.listo), 32'(exp_listo));
      chk("ocupado", 32'(bus.ocupado), 32'(e_cnt + 2 <= ready_at));
      if (exp_listo) begin
        held_bin = exp_q[0].bin;
        held_err = exp_q[0].err;
        exp_q.pop_front();
        n_done++;
      end
      chk("dato_bin", 32'(bus.dato_bin), 32'(held_bin));
      chk("error_bcd", 32'(bus.error_bcd), 32'(held_err));
      if (bus.listo)
        $display("xact %0d: dato_bin=%0d error_bcd=%0d", n_done, bus.dato_bin, bus.error_bcd);
    end
  end

  task automatic start(input logic [4*DIGITS-1:0] v);
    @(negedge clk);
    bus.inicio   = 1'b1;
    bus.dato_bcd = v;
    @(negedge clk);
    bus.inicio   = 1'b0;
  endtask

  task automatic wait_listo(output int k);
    k = 0;
    while (!bus.listo && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.listo) chk("listo_timeout", 32'(k), 32'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int               lat;
    int               extra;
    int               base;
    logic [BIN_W-1:0] b;
    logic             er;

    reset = 1'b0;
    bus.inicio = 1'b0;
    bus.dato_bcd = '0;

    // Pin the model to hand-computed values.
    ref_conv(8'h59, b, er); chk("ref_59", 32'(b), 32'd59); chk("ref_59_err", 32'(er), 32'd0);
    ref_conv(8'h99, b, er); chk("ref_99", 32'(b), 32'h63);
    ref_conv(8'h1A, b, er); chk("ref_1A", 32'(b), 32'h7F); chk("ref_1A_err", 32'(er), 32'd1);

    repeat (2) @(negedge clk);
    chk("rst_bin", 32'(bus.dato_bin), 32'd0);
    chk("rst_listo", 32'(bus.listo), 32'd0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
    reset = 1'b1;

    // 1: zero operand, full latency
    start(8'h00); wait_listo(lat);
    chk("t1_lat", 32'(lat), 32'd9);
    chk("t1_bin", 32'(bus.dato_bin), 32'd0);
    chk("t1_err", 32'(bus.error_bcd), 32'd0);

    // 2: largest values
    start(8'h59); wait_listo(lat);
    chk("t2_59", 32'(bus.dato_bin), 32'h3B);
    start(8'h99); wait_listo(lat);
    chk("t2_99", 32'(bus.dato_bin), 32'h63);
    chk("t2_err", 32'(bus.error_bcd), 32'd0);

    // 3: invalid nibble returns early, then a valid one clears the flag
    start(8'h1A); wait_listo(lat);
    chk("t3_lat", 32'(lat), 32'd2);
    chk("t3_bin", 32'(bus.dato_bin), 32'h7F);
    chk("t3_err", 32'(bus.error_bcd), 32'd1);
    start(8'h07); wait_listo(lat);
    chk("t3_07", 32'(bus.dato_bin), 32'd7);
    chk("t3_07_err", 32'(bus.error_bcd), 32'd0);

    // 4: request while busy is ignored
    start(8'h45);
    repeat (2) @(negedge clk);
    bus.inicio = 1'b1; bus.dato_bcd = 8'h23;
    @(negedge clk);
    bus.inicio = 1'b0;
    wait_listo(lat);
    chk("t4_45", 32'(bus.dato_bin), 32'd45);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.listo) extra++;
    end
    chk("t4_single", 32'(extra), 32'd0);

    // 5: reset in the middle of SHIFT
    start(8'h37);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_bin", 32'(bus.dato_bin), 32'd0);
    chk("t5_err", 32'(bus.error_bcd), 32'd0);
    chk("t5_listo", 32'(bus.listo), 32'd0);
    chk("t5_ocupado", 32'(bus.ocupado), 32'd0);
    reset = 1'b1;
    start(8'h12); wait_listo(lat);
    chk("t5_12", 32'(bus.dato_bin), 32'd12);

    // 6: every valid code back-to-back, then every invalid code back-to-back
    repeat (3) @(negedge clk);
    base = n_done;
    for (int v = 0; v < 100; v++) begin
      bus.dato_bcd = {4'(v / 10), 4'(v % 10)};
      bus.inicio = 1'b1;
      repeat (BIN_W + 2) @(negedge clk);
    end
    bus.inicio = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_valid_count", 32'(n_done - base), 32'd100);

    base = n_done;
    for (int v = 0; v < 256; v++) begin
      if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9)) begin
        bus.dato_bcd = 8'(v);
        bus.inicio = 1'b1;
        repeat (2) @(negedge clk);
      end
    end
    bus.inicio = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_invalid_count", 32'(n_done - base), 32'd156);
    chk("t6_last_bin", 32'(bus.dato_bin), 32'h7F);
    chk("t6_last_err", 32'(bus.error_bcd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
